writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RISC-V core, directly upstream of the register file. It accepts completed instructions from the memory stage through a valid/ready handshake and formats load data. It buffers up to two results in a FIFO, then drives the register file write port (rd, write enable, write data). It also answers an operand-bypass query from decode and counts retired instructions.

## Interface
- XLEN, 32, datapath width
- DEPTH, 2, result FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  5  destination register
- in_wb_en  in  1  instruction writes rd
- in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- in_alu_result  in  XLEN  ALU result
- in_pc_plus4  in  XLEN  link value
- in_mem_data  in  XLEN  raw aligned load word
- in_funct3  in  3  load type
- in_addr_lsb  in  2  load address bits [1:0]
- wb_stall  in  1  register file port unavailable this cycle
- reg_write_en  out  1  to register file
- rd  out  5  to register file
- write_data  out  XLEN  to register file
- query_rs  in  5  decode source register to check
- query_hit  out  1  a buffered, unwritten result targets query_rs
- query_data  out  XLEN  that result (youngest match)
- retire_count  out  32  instructions popped since reset

## Operation
- Push: in_valid && in_ready. The entry stores rd, wb_en, and final write data, formatted at enqueue.
- Data select: ALU → in_alu_result, PC+4 → in_pc_plus4, load → formatted in_mem_data.
- Load format (funct3):
  - 000 LB: byte addr_lsb, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half addr_lsb[1], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: whole word.
  - Any other funct3: raw word.
- Pop: head valid && !wb_stall. Every popped entry increments retire_count, including wb_en=0 entries; the counter wraps at 2^32.
- reg_write_en = head valid && head.wb_en && head.rd≠0 && !wb_stall. rd and write_data always show the head fields, or 0 when empty.
- Query: query_hit=1 when any valid entry has wb_en && rd≠0 && rd==query_rs. query_data comes from the youngest such entry, else 0. Combinational, and independent of wb_stall.
- in_ready = count < DEPTH. It is a registered-state function and does not look ahead to a same-cycle pop.
- Simultaneous push and pop: allowed when count<DEPTH; count is unchanged.
- Full: in_ready=0; the upstream stage holds its inputs.
- Empty: no write; query_hit=0.
- Pointers wrap modulo DEPTH.

## Timing
- Latency: a pushed entry reaches the head earliest in the next cycle. With an empty FIFO and no stall, the register-file write happens on the edge after the accept edge.
- All FIFO state, pointers, count, and retire_count update on the rising clk edge.
- Reset values, including reset mid-operation: count 0, pointers 0, all entries invalid, retire_count 0.
- Output reset values: in_ready 1, reg_write_en 0, rd 0, write_data 0, query_hit 0, query_data 0.
- Buffered entries are discarded on reset, and no write is issued in the reset cycle.
- No combinational path from in_* to reg_write_en, rd, or write_data. query_* is combinational from query_rs and registered state only.

## Structure
- Shared package (core_pkg): XLEN, the wb_sel encodings (WB_ALU, WB_MEM, WB_PC4), and the load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- One sub-module: load_formatter, purely combinational (funct3, addr_lsb, word → XLEN result).
- FIFO storage, pointers, query match, and counter live in the top module.

## Test plan
- LB, addr_lsb=2, mem_data 0x12_80_34_56, rd=5, wb_en=1 → next cycle reg_write_en=1, rd=5, write_data 0xFFFFFF80. LBU → 0x00000080.
- LHU, addr_lsb=2, mem_data 0xBEEF0001, rd=7 → write_data 0x0000BEEF. LH → 0xFFFFBEEF.
- rd=0 with wb_en=1, ALU result 0xDEADBEEF → reg_write_en stays 0, and retire_count still increments by 1.
- wb_stall=1 held, push 3 back-to-back: in_ready falls to 0 after 2 accepts. Release the stall → writes occur in order, one per cycle, then in_ready returns to 1.
- Two entries both rd=9 (0x11 older, 0x22 younger), wb_stall=1, query_rs=9 → query_hit=1, query_data 0x22. Query for rd=0 → hit=0.
- Assert reset with 2 entries buffered and retire_count=5 → next cycle count 0, retire_count 0, reg_write_en 0, in_ready 1.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Constants and types shared by the RISC-V core writeback slice.
//            Holds the datapath width, the writeback-select encodings, the
//            load funct3 codes and the result-FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 32;

  // Writeback data select (2'b11 is reserved and behaves as ALU)
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One buffered result: data is already in its final register-file form
  typedef struct packed {
    logic [4:0]      rd;
    logic            wb_en;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage_if
// Purpose  : Memory-stage to writeback-stage handshake bundle.
// Ports    : in_valid/in_ready handshake, in_rd, in_wb_en, in_wb_sel,
//            in_alu_result, in_pc_plus4, in_mem_data, in_funct3, in_addr_lsb.
//            master = memory stage (producer), slave = writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_stage_if;
  import core_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_wb_en;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus4;
  logic [XLEN-1:0] in_mem_data;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lsb;

  modport master (
    output in_valid, in_rd, in_wb_en, in_wb_sel, in_alu_result,
           in_pc_plus4, in_mem_data, in_funct3, in_addr_lsb,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wb_en, in_wb_sel, in_alu_result,
           in_pc_plus4, in_mem_data, in_funct3, in_addr_lsb,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/writeback_stage_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : load_formatter
// Purpose  : Purely combinational load-data alignment and extension.
// Ports    : funct3   - load type
//            addr_lsb - load address bits [1:0]
//            word     - raw aligned load word
//            result   - formatted XLEN value
// Revision : 1.0 - initial release
// ============================================================================
module load_formatter
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    case (addr_lsb)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  // Halfword selection only looks at bit 1; bit 0 is ignored for halves.
  assign w_half = addr_lsb[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, w_half};
      default: result = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final pipeline stage. Accepts completed instructions from the
//            memory stage, formats load data at enqueue, buffers results in a
//            small FIFO and drives the register-file write port from its head.
//            Also answers decode's operand-bypass query and counts retirements.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            mem               - memory-stage handshake (slave side)
//            wb_stall          - register-file port unavailable this cycle
//            reg_write_en, rd, write_data - register-file write port
//            query_rs          - decode source register
//            query_hit/data    - youngest buffered result for query_rs
//            retire_count      - entries popped since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage
  import core_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic             clk,
  input  logic             reset,
  writeback_stage_if.slave mem,
  input  logic             wb_stall,
  output logic             reg_write_en,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  write_data,
  input  logic [4:0]       query_rs,
  output logic             query_hit,
  output logic [XLEN-1:0]  query_data,
  output logic [31:0]      retire_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wb_entry_t        r_entry [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_retire;

  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_load_data;
  wb_entry_t        w_new;
  wb_entry_t        w_head;

  // --------------------------------------------------------------------------
  // Enqueue side: data is formatted before storage so the head is ready to
  // write with no further logic between the FIFO and the register file.
  // --------------------------------------------------------------------------
  load_formatter u_load_formatter (
    .funct3   (mem.in_funct3),
    .addr_lsb (mem.in_addr_lsb),
    .word     (mem.in_mem_data),
    .result   (w_load_data)
  );

  always_comb begin
    w_new.rd    = mem.in_rd;
    w_new.wb_en = mem.in_wb_en;
    case (mem.in_wb_sel)
      WB_MEM:  w_new.data = w_load_data;
      WB_PC4:  w_new.data = mem.in_pc_plus4;
      default: w_new.data = mem.in_alu_result;
    endcase
  end

  assign w_empty     = (r_count == '0);
  // Ready depends on registered occupancy only, never on a same-cycle pop.
  assign w_ready     = (r_count < CNT_W'(DEPTH));
  assign mem.in_ready = w_ready;

  assign w_push = mem.in_valid && w_ready;
  // Nothing leaves the FIFO while reset is asserted.
  assign w_pop  = !w_empty && !wb_stall && !reset;

  // --------------------------------------------------------------------------
  // Storage: contents need no reset, validity is carried by r_count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry[r_tail] <= w_new;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and retirement counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_retire <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head   <= r_head + PTR_W'(1);
        r_retire <= r_retire + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign retire_count = r_retire;

  // --------------------------------------------------------------------------
  // Register-file port: driven purely from registered head state.
  // --------------------------------------------------------------------------
  assign w_head       = r_entry[r_head];
  assign rd           = w_empty ? 5'd0 : w_head.rd;
  assign write_data   = w_empty ? '0 : w_head.data;
  assign reg_write_en = w_pop && w_head.wb_en && (w_head.rd != 5'd0);

  // --------------------------------------------------------------------------
  // Bypass query: walk from oldest to youngest so the last match wins.
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] w_qidx;

  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    w_qidx     = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_qidx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) &&
          r_entry[w_qidx].wb_en &&
          (r_entry[w_qidx].rd != 5'd0) &&
          (r_entry[w_qidx].rd == query_rs)) begin
        query_hit  = 1'b1;
        query_data = r_entry[w_qidx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage: table-driven vectors,
//            directed multi-cycle sequences and a randomized phase, all
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;
  import core_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        wb_stall;
  logic        reg_write_en;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [4:0]  query_rs;
  logic        query_hit;
  logic [31:0] query_data;
  logic [31:0] retire_count;

  writeback_stage_if mem_if ();

  writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (mem_if),
    .wb_stall     (wb_stall),
    .reg_write_en (reg_write_en),
    .rd           (rd),
    .write_data   (write_data),
    .query_rs     (query_rs),
    .query_hit    (query_hit),
    .query_data   (query_data),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_retire;
  bit          last_push;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(logic [2:0] f3, logic [1:0] lsb, logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lsb)) & 32'hFF;
    h = (w >> (16 * lsb[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] sel_data();
    case (mem_if.in_wb_sel)
      2'b01:   return fmt(mem_if.in_funct3, mem_if.in_addr_lsb, mem_if.in_mem_data);
      2'b10:   return mem_if.in_pc_plus4;
      default: return mem_if.in_alu_result;
    endcase
  endfunction

  task automatic check_outputs();
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_hit;
    logic [31:0] e_qd;
    int          n;
    n     = q.size();
    e_rd  = (n > 0) ? q[0].rd : 5'd0;
    e_wd  = (n > 0) ? q[0].data : 32'd0;
    e_we  = (n > 0) && q[0].wb_en && (q[0].rd != 0) && !wb_stall && !reset;
    e_hit = 1'b0;
    e_qd  = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!e_hit && q[i].wb_en && q[i].rd != 0 && q[i].rd == query_rs) begin
        e_hit = 1'b1;
        e_qd  = q[i].data;
      end
    end
    chk("in_ready",     {31'd0, mem_if.in_ready}, {31'd0, (n < DEPTH)});
    chk("reg_write_en", {31'd0, reg_write_en},    {31'd0, e_we});
    chk("rd",           {27'd0, rd},              {27'd0, e_rd});
    chk("write_data",   write_data,               e_wd);
    chk("query_hit",    {31'd0, query_hit},       {31'd0, e_hit});
    chk("query_data",   query_data,               e_qd);
    chk("retire_count", retire_count,             exp_retire);
  endtask

  // One clock cycle: check pre-edge outputs, advance DUT and model together.
  task automatic tick();
    ent_t e;
    bit   push;
    bit   pop;
    #1;
    check_outputs();
    push    = mem_if.in_valid && (q.size() < DEPTH);
    pop     = (q.size() > 0) && !wb_stall && !reset;
    e.rd    = mem_if.in_rd;
    e.wb_en = mem_if.in_wb_en;
    e.data  = sel_data();
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_retire = 32'd0;
      last_push  = 1'b0;
    end else begin
      if (pop) begin
        q.delete(0);
        exp_retire = exp_retire + 32'd1;
      end
      if (push) q.push_back(e);
      last_push = push;
    end
    #1;
  endtask

  task automatic drive(bit v, logic [4:0] r, bit we, logic [1:0] sel,
                       logic [31:0] alu, logic [31:0] pc4, logic [31:0] md,
                       logic [2:0] f3, logic [1:0] lsb);
    mem_if.in_valid      = v;
    mem_if.in_rd         = r;
    mem_if.in_wb_en      = we;
    mem_if.in_wb_sel     = sel;
    mem_if.in_alu_result = alu;
    mem_if.in_pc_plus4   = pc4;
    mem_if.in_mem_data   = md;
    mem_if.in_funct3     = f3;
    mem_if.in_addr_lsb   = lsb;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] md;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        wb_en;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{2'b01, 3'b000, 2'd2, 32'h12803456, 32'h0, 32'h0, 5'd5,  1'b1, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{2'b01, 3'b100, 2'd2, 32'h12803456, 32'h0, 32'h0, 5'd5,  1'b1, 1'b1, 32'h00000080};
    vecs[2]  = '{2'b01, 3'b101, 2'd2, 32'hBEEF0001, 32'h0, 32'h0, 5'd7,  1'b1, 1'b1, 32'h0000BEEF};
    vecs[3]  = '{2'b01, 3'b001, 2'd2, 32'hBEEF0001, 32'h0, 32'h0, 5'd7,  1'b1, 1'b1, 32'hFFFFBEEF};
    vecs[4]  = '{2'b00, 3'b000, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd0,  1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'h00001004, 5'd1,  1'b1, 1'b1, 32'h00001004};
    vecs[6]  = '{2'b01, 3'b010, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd2,  1'b1, 1'b1, 32'hCAFEF00D};
    vecs[7]  = '{2'b11, 3'b000, 2'd0, 32'hFFFFFFFF, 32'h01234567, 32'h9, 5'd3, 1'b1, 1'b1, 32'h01234567};
    vecs[8]  = '{2'b01, 3'b000, 2'd0, 32'h0000007F, 32'h0, 32'h0, 5'd4,  1'b1, 1'b1, 32'h0000007F};
    vecs[9]  = '{2'b01, 3'b011, 2'd1, 32'h89ABCDEF, 32'h0, 32'h0, 5'd6,  1'b1, 1'b1, 32'h89ABCDEF};
    vecs[10] = '{2'b00, 3'b000, 2'd0, 32'h0, 32'h00000055, 32'h0, 5'd8,  1'b0, 1'b0, 32'h00000055};
    vecs[11] = '{2'b01, 3'b001, 2'd0, 32'h00018000, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 32'hFFFF8000};
    vecs[12] = '{2'b01, 3'b100, 2'd3, 32'hAB000000, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 32'h000000AB};
  end

  // ---------------------------------------------------------------- test
  initial begin
    logic [31:0] ret_before;
    reset    = 1'b1;
    wb_stall = 1'b0;
    query_rs = 5'd0;
    drive(0, 5'd0, 0, 2'b00, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    q.delete();
    exp_retire = 32'd0;
    last_push  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    #1;
    chk("rst_in_ready", {31'd0, mem_if.in_ready}, 32'd1);
    chk("rst_retire",   retire_count, 32'd0);
    tick();

    // Table-driven single-entry vectors
    for (int i = 0; i < NV; i++) begin
      query_rs = vecs[i].rd;
      drive(1, vecs[i].rd, vecs[i].wb_en, vecs[i].sel, vecs[i].alu,
            vecs[i].pc4, vecs[i].md, vecs[i].f3, vecs[i].lsb);
      tick();
      mem_if.in_valid = 1'b0;
      #1;
      chk("tbl_we", {31'd0, reg_write_en}, {31'd0, vecs[i].exp_we});
      chk("tbl_rd", {27'd0, rd},           {27'd0, vecs[i].rd});
      chk("tbl_wd", write_data,            vecs[i].exp_wd);
      ret_before = exp_retire;
      tick();
      chk("tbl_retire", retire_count, ret_before + 32'd1);
    end

    // Stall-held back-to-back pushes: third must wait
    wb_stall = 1'b1;
    drive(1, 5'd1, 1, 2'b00, 32'hA1, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    drive(1, 5'd2, 1, 2'b00, 32'hB2, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    drive(1, 5'd3, 1, 2'b00, 32'hC3, 32'd0, 32'd0, 3'd0, 2'd0);
    #1;
    chk("full_ready", {31'd0, mem_if.in_ready}, 32'd0);
    tick();
    wb_stall = 1'b0;
    #1;
    chk("order1_we", {31'd0, reg_write_en}, 32'd1);
    chk("order1_rd", {27'd0, rd}, 32'd1);
    chk("order1_wd", write_data, 32'hA1);
    tick();
    #1;
    chk("order2_rd", {27'd0, rd}, 32'd2);
    chk("order2_wd", write_data, 32'hB2);
    chk("order2_ready", {31'd0, mem_if.in_ready}, 32'd1);
    tick();
    mem_if.in_valid = 1'b0;
    #1;
    chk("order3_rd", {27'd0, rd}, 32'd3);
    chk("order3_wd", write_data, 32'hC3);
    tick();
    #1;
    chk("drain_ready", {31'd0, mem_if.in_ready}, 32'd1);
    chk("drain_we", {31'd0, reg_write_en}, 32'd0);

    // Reset, retire five, then query and reset mid-operation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd12, 1, 2'b00, 32'h100 + i, 32'd0, 32'd0, 3'd0, 2'd0);
      tick();
    end
    mem_if.in_valid = 1'b0;
    tick();
    chk("retire5", retire_count, 32'd5);
    wb_stall = 1'b1;
    drive(1, 5'd9, 1, 2'b00, 32'h11, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    drive(1, 5'd9, 1, 2'b00, 32'h22, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    mem_if.in_valid = 1'b0;
    query_rs = 5'd9;
    #1;
    chk("q9_hit",  {31'd0, query_hit}, 32'd1);
    chk("q9_data", query_data, 32'h22);
    query_rs = 5'd0;
    #1;
    chk("q0_hit",  {31'd0, query_hit}, 32'd0);
    query_rs = 5'd9;
    wb_stall = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rstcyc_we", {31'd0, reg_write_en}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready",  {31'd0, mem_if.in_ready}, 32'd1);
    chk("post_rst_we",     {31'd0, reg_write_en}, 32'd0);
    chk("post_rst_retire", retire_count, 32'd0);
    chk("post_rst_hit",    {31'd0, query_hit}, 32'd0);
    chk("post_rst_wd",     write_data, 32'd0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (!(mem_if.in_valid && !last_push)) begin
        drive(($urandom_range(99, 0) < 65), 5'($urandom_range(7, 0)),
              1'($urandom_range(1, 0) | $urandom_range(1, 0)),
              2'($urandom_range(3, 0)), $urandom, $urandom, $urandom,
              3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)));
      end
      wb_stall = ($urandom_range(99, 0) < 35);
      query_rs = 5'($urandom_range(7, 0));
      reset    = ($urandom_range(99, 0) < 2);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
